// File: rtl/rgb_leds_pkg.sv
// rtl/rgb_leds_pkg.sv - shared constants and types for the rgb_leds peripheral
// Purpose: register indices, AXI response code, control bit position and the
//          duty type used by the PWM channels. No ports.
package rgb_leds_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_RED   = 2'd1;
  localparam logic [1:0] REG_GREEN = 2'd2;
  localparam logic [1:0] REG_BLUE  = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int CTRL_EN_BIT = 0;

  localparam int DUTY_WIDTH = 8;
  typedef logic [DUTY_WIDTH-1:0] duty_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// rtl/rgb_pwm_channel.sv - one PWM colour channel with shadowed duty
// Purpose: compares the shared PWM counter against a shadow copy of the duty
//          register; the shadow only reloads on the counter wrap so a duty
//          change never cuts a period short.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   cnt       - shared PWM counter
//   duty      - live duty value from the register bank
//   wrap      - strobe, high in the cycle the counter wraps to 0
//   enable    - shadowed global enable
//   led       - registered LED drive (polarity set by ACTIVE_HIGH)
module rgb_pwm_channel #(
  parameter int W           = 8,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] duty,
  input  logic         wrap,
  input  logic         enable,
  output logic         led
);

  logic [W-1:0] shadow;
  logic         on;
  logic         led_q;

  assign on  = enable && (cnt < shadow);
  assign led = led_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      led_q  <= (ACTIVE_HIGH == 0);
    end else begin
      if (wrap) begin
        shadow <= duty;
      end
      led_q <= (ACTIVE_HIGH != 0) ? on : !on;
    end
  end

endmodule

// File: rtl/rgb_leds_axil_slave.sv
// rtl/rgb_leds_axil_slave.sv - AXI4-Lite register bank driving an RGB PWM LED
// Purpose: four 32-bit read/write registers (CTRL, RED, GREEN, BLUE) behind
//          an AXI4-Lite responder; a shared prescaler and PWM counter feed
//          three rgb_pwm_channel instances.
// Ports:
//   ACLK, ARESET      - clock and synchronous active-high reset
//   s_axi_aw*/w*/b*   - write address, write data and write response channels
//   s_axi_ar*/r*      - read address and read data channels
//   led_r/led_g/led_b - PWM outputs
module rgb_leds_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_WIDTH          = 8,
  parameter int PRESCALE           = 4,
  parameter int LED_ACTIVE_HIGH    = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            led_r,
  output logic                            led_g,
  output logic                            led_b
);

  import rgb_leds_pkg::*;

  logic [3:0][31:0]       regs;
  logic                   rst_done;
  logic                   aw_q;
  logic                   w_q;
  logic [1:0]             aw_idx;
  logic [31:0]            wdata_q;
  logic [3:0]             wstrb_q;
  logic                   bvalid_q;
  logic                   rvalid_q;
  logic [31:0]            rdata_q;

  logic [15:0]            presc;
  logic [PWM_WIDTH-1:0]   cnt;
  logic                   tick;
  logic                   wrap;
  logic                   en_shadow;

  logic                   unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // rst_done keeps every ready low while ARESET is held and for the first
  // cycle after it, so the reset state shows all handshake outputs at 0.
  assign s_axi_awready = rst_done && !aw_q && !bvalid_q;
  assign s_axi_wready  = rst_done && !w_q && !bvalid_q;
  assign s_axi_arready = rst_done && !rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs     <= '0;
      rst_done <= 1'b0;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      aw_idx   <= 2'd0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rst_done <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_q   <= 1'b1;
        aw_idx <= s_axi_awaddr[3:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_q     <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      // Commit one cycle after both beats are held; readies are low by then
      // so the latch clears cannot collide with a new handshake.
      if (aw_q && w_q) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) begin
            regs[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
        aw_q     <= 1'b0;
        w_q      <= 1'b0;
        bvalid_q <= 1'b1;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      // Sampling regs here sees the pre-commit value if a write lands on
      // the same edge.
      if (s_axi_arvalid && s_axi_arready) begin
        rdata_q  <= regs[s_axi_araddr[3:2]];
        rvalid_q <= 1'b1;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign tick = (presc == 16'(PRESCALE - 1));
  assign wrap = tick && (cnt == '1);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      presc     <= '0;
      cnt       <= '0;
      en_shadow <= 1'b0;
    end else begin
      if (tick) begin
        presc <= '0;
        cnt   <= cnt + 1'b1;
      end else begin
        presc <= presc + 16'd1;
      end
      if (wrap) begin
        en_shadow <= regs[REG_CTRL][CTRL_EN_BIT];
      end
    end
  end

  rgb_pwm_channel #(.W(PWM_WIDTH), .ACTIVE_HIGH(LED_ACTIVE_HIGH)) u_red (
    .clk(ACLK), .rst(ARESET), .cnt(cnt), .duty(regs[REG_RED][PWM_WIDTH-1:0]),
    .wrap(wrap), .enable(en_shadow), .led(led_r)
  );

  rgb_pwm_channel #(.W(PWM_WIDTH), .ACTIVE_HIGH(LED_ACTIVE_HIGH)) u_green (
    .clk(ACLK), .rst(ARESET), .cnt(cnt), .duty(regs[REG_GREEN][PWM_WIDTH-1:0]),
    .wrap(wrap), .enable(en_shadow), .led(led_g)
  );

  rgb_pwm_channel #(.W(PWM_WIDTH), .ACTIVE_HIGH(LED_ACTIVE_HIGH)) u_blue (
    .clk(ACLK), .rst(ARESET), .cnt(cnt), .duty(regs[REG_BLUE][PWM_WIDTH-1:0]),
    .wrap(wrap), .enable(en_shadow), .led(led_b)
  );

endmodule

// File: tb/tb_rgb_leds_axil_slave.sv
// tb/tb_rgb_leds_axil_slave.sv - directed self-checking bench for rgb_leds_axil_slave
module tb_rgb_leds_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        led_r, led_g, led_b;

  int total = 0;
  int bad = 0;

  always #5 ACLK = ~ACLK;

  rgb_leds_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .PWM_WIDTH(8),
    .PRESCALE(1), .LED_ACTIVE_HIGH(1)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_aw(input logic [3:0] a);
    int n = 0;
    s_axi_awaddr = a;
    s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_axi_awready) begin
      total++; bad++;
      $display("FAIL aw_timeout: awready=%0b required=1", s_axi_awready);
    end
    @(negedge ACLK);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi_wdata = d;
    s_axi_wstrb = s;
    s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_axi_wready) begin
      total++; bad++;
      $display("FAIL w_timeout: wready=%0b required=1", s_axi_wready);
    end
    @(negedge ACLK);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp);
    int n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_axi_bvalid) begin
      total++; bad++;
      $display("FAIL b_timeout: bvalid=%0b required=1", s_axi_bvalid);
    end
    for (int k = 0; k < hold; k++) begin
      total++;
      if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100) begin
        bad++;
        $display("FAIL b_hold: {bvalid,awready,wready}=%b required=100", {s_axi_bvalid, s_axi_awready, s_axi_wready});
      end
      @(negedge ACLK);
    end
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge ACLK);
    s_axi_bready = 1'b0;
    total++;
    if (s_axi_bvalid !== 1'b0) begin
      bad++;
      $display("FAIL b_clear: bvalid=%0b required=0", s_axi_bvalid);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b(0, resp);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    @(negedge ACLK);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_axi_rvalid) begin
      total++; bad++;
      $display("FAIL r_timeout: rvalid=%0b required=1", s_axi_rvalid);
    end
    d = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(negedge ACLK);
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_handshake: got %b required 00000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
    end
    total++;
    if ({s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 36'h0) begin
      bad++;
      $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h required 0", s_axi_bresp, s_axi_rresp, s_axi_rdata);
    end
    total++;
    if ({led_r, led_g, led_b} !== 3'b000) begin
      bad++;
      $display("FAIL reset_leds: got %b required 000", {led_r, led_g, led_b});
    end
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      bad++;
      $display("FAIL post_reset_ready: got %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_seq_rw();
    logic [1:0]  r;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, r);
      total++;
      if (r !== 2'b00) begin
        bad++;
        $display("FAIL seq_bresp[%0d]: got %b required 00", i, r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      total++;
      if (d !== 32'(i + 1) || r !== 2'b00) begin
        bad++;
        $display("FAIL seq_read[%0d]: rdata=%h rresp=%b required %h/00", i, d, r, 32'(i + 1));
      end
    end
  endtask

  task automatic test_wstrb();
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(4'h4, 32'h0000_00AA, 4'b0001, r);
    axi_read(4'h4, d, r);
    total++;
    if (d !== 32'hFFFF_FFAA) begin
      bad++;
      $display("FAIL wstrb_low: rdata=%h required ffffffaa", d);
    end
    axi_write(4'h5, 32'h0012_0000, 4'b0100, r);
    axi_read(4'h7, d, r);
    total++;
    if (d !== 32'hFF12_FFAA) begin
      bad++;
      $display("FAIL wstrb_byte2: rdata=%h required ff12ffaa", d);
    end
  endtask

  task automatic test_split_order();
    logic [1:0]  r;
    logic [31:0] d;
    int          extra;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) send_aw(4'hC); else send_w(32'h5566_7788, 4'hF);
      repeat (3) @(negedge ACLK);
      total++;
      if (s_axi_bvalid !== 1'b0) begin
        bad++;
        $display("FAIL split_early_b[%0d]: bvalid=%0b required 0", pass, s_axi_bvalid);
      end
      if (pass == 0) send_w(32'h1122_3344, 4'hF); else send_aw(4'hC);
      wait_b(5, r);
      extra = 0;
      for (int k = 0; k < 6; k++) begin
        if (s_axi_bvalid) extra++;
        @(negedge ACLK);
      end
      total++;
      if (extra !== 0 || r !== 2'b00) begin
        bad++;
        $display("FAIL split_single_b[%0d]: extra_bvalid=%0d bresp=%b required 0/00", pass, extra, r);
      end
    end
    axi_read(4'hC, d, r);
    total++;
    if (d !== 32'h5566_7788) begin
      bad++;
      $display("FAIL split_read: rdata=%h required 55667788", d);
    end
  endtask

  task automatic test_raw_same_cycle();
    logic [1:0]  r;
    logic [31:0] d;
    s_axi_awaddr = 4'h8; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0055; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    total++;
    if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
      bad++;
      $display("FAIL raw_ready: {awready,wready}=%b required 11", {s_axi_awready, s_axi_wready});
    end
    @(negedge ACLK);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 4'h8; s_axi_arvalid = 1'b1;
    total++;
    if ({s_axi_arready, s_axi_bvalid} !== 2'b10) begin
      bad++;
      $display("FAIL raw_commit_cycle: {arready,bvalid}=%b required 10", {s_axi_arready, s_axi_bvalid});
    end
    @(negedge ACLK);
    s_axi_arvalid = 1'b0;
    total++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b11 || s_axi_rdata !== 32'h0000_0003) begin
      bad++;
      $display("FAIL raw_old_value: bvalid=%0b rvalid=%0b rdata=%h required 1/1/00000003",
               s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
    end
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge ACLK);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    axi_read(4'h8, d, r);
    total++;
    if (d !== 32'h0000_0055) begin
      bad++;
      $display("FAIL raw_new_value: rdata=%h required 00000055", d);
    end
  endtask

  task automatic test_reset_abort();
    logic [1:0]  r;
    logic [31:0] d;
    int          seen = 0;
    send_aw(4'h4);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (s_axi_bvalid) seen++;
      @(negedge ACLK);
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_bvalid: bvalid cycles=%0d required 0", seen);
    end
    axi_read(4'h4, d, r);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL abort_read: rdata=%h required 00000000", d);
    end
  endtask

  task automatic test_pwm();
    logic [1:0] r;
    int n;
    int cr, cg, cb;
    axi_write(4'h0, 32'd1, 4'hF, r);
    axi_write(4'h4, 32'd64, 4'hF, r);
    axi_write(4'h8, 32'd0, 4'hF, r);
    axi_write(4'hC, 32'd255, 4'hF, r);
    n = 0;
    while (led_b !== 1'b1 && n < 600) begin @(negedge ACLK); n++; end
    n = 0;
    while (led_b !== 1'b0 && n < 600) begin @(negedge ACLK); n++; end
    total++;
    if (led_b !== 1'b0) begin
      bad++;
      $display("FAIL pwm_sync_timeout: led_b=%0b required 0", led_b);
    end
    cr = 0; cg = 0; cb = 0;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          @(negedge ACLK);
          cr += int'(led_r); cg += int'(led_g); cb += int'(led_b);
        end
      end
      begin
        repeat (100) @(negedge ACLK);
        axi_write(4'h4, 32'd128, 4'hF, r);
      end
    join
    total++;
    if (cr !== 64 || cg !== 0 || cb !== 255) begin
      bad++;
      $display("FAIL pwm_period1: r=%0d g=%0d b=%0d required 64/0/255", cr, cg, cb);
    end
    cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge ACLK);
      cr += int'(led_r); cg += int'(led_g); cb += int'(led_b);
    end
    total++;
    if (cr !== 128 || cg !== 0 || cb !== 255) begin
      bad++;
      $display("FAIL pwm_period2: r=%0d g=%0d b=%0d required 128/0/255", cr, cg, cb);
    end
  endtask

  initial begin
    @(negedge ACLK);
    test_reset();
    test_seq_rw();
    test_wstrb();
    test_split_order();
    test_raw_same_cycle();
    test_reset_abort();
    test_pwm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
